ps2_mouse_rx: RTL and testbench
===============================

// Module: ps2_mouse_rx
// PURPOSE
//   Native PS/2 mouse host. Deserialises device->host frames from raw PS/2 clock/data pins.
//   Assembles standard 3-byte movement packets into the 25-bit ps2_mouse bus
//   (toggle-on-new-packet), the same format the mouse-port adapters (Kempston etc.) consume.
//   Sits between the top-level PS/2 pins and any mouse-port decoder.
// PARAMETERS
//   CLK_HZ        50_000_000  clk_sys frequency; used to derive all time-based counts
//   FILTER_CYCLES 8           consecutive equal samples required to accept a ps2_clk level change
//   TIMEOUT_US    2000        idle time without a ps2_clk falling edge that aborts a frame/packet
// PORTS
//   clk_sys    in   1   system clock
//   reset      in   1   synchronous, active-high
//   ps2_clk_i  in   1   PS/2 clock pin input (async)
//   ps2_dat_i  in   1   PS/2 data pin input (async)
//   ps2_clk_o  out  1   0 = drive clock pin low, 1 = release (open-drain)
//   ps2_dat_o  out  1   0 = drive data pin low, 1 = release (open-drain)
//   ps2_mouse  out  25  [7:0] status byte, [15:8] X delta, [23:16] Y delta, [24] packet toggle
// BEHAVIOUR
//   Reset: ps2_mouse=0; ps2_clk_o=ps2_dat_o=1; bit/byte counters, filter and timeout cleared.
//   Input path:
//     - 2-FF synchronisers on both pins.
//     - ps2_clk glitch filter: level accepted after FILTER_CYCLES equal samples.
//     - Falling edge of the filtered clock samples synchronised data.
//   Frame: start(0), 8 data bits LSB first, odd parity, stop(1); 11 falling edges.
//     - Bad start, parity or stop: byte discarded, packet index forced to 0.
//   Packet alignment:
//     - Byte at index 0 accepted only if bit3=1; otherwise dropped, index stays 0.
//     - Indices 1 and 2 accepted unconditionally.
//   Publish: on the clk_sys cycle after the stop bit of byte 2 is sampled:
//     - ps2_mouse[23:0] <= {b2,b1,b0} and ps2_mouse[24] inverts, in the same cycle.
//     - Index returns to 0. ps2_mouse holds its value between packets.
//     - Sign and overflow bits (b0[7:4]) are passed through unmodified.
//   Timeout: a counter of TIMEOUT_US*CLK_HZ/1e6 cycles is reloaded on every filtered falling edge.
//     - On expiry with bit count != 0 or index != 0: both cleared, no publish.
//     - Expiry when fully idle: no effect.
//   Simultaneous events: reset dominates everything. A falling edge and timeout expiry in the
//     same cycle count as an edge (timeout ignored).
//   Packets arriving back-to-back publish each packet; no buffering beyond one packet.
// CONFIGURATION
//   Macro PS2_MOUSE_INIT_EN:
//   Defined: host-side init FSM sends 0xF4 (Enable Data Reporting) after reset. States:
//     - WAIT: 500 ms power-up wait.
//     - INHIBIT: ps2_clk_o=0 for 120 us.
//     - REQ: ps2_dat_o=0, then release clk.
//     - SEND: on each device falling edge present next bit: F4 LSB first, parity=0, stop=1
//       (release).
//     - ACK: expect data low on next falling edge.
//     - WAIT_FA: next received byte must be 0xFA. 0xFA consumed, never enters packet assembly.
//     - RUN: normal reception.
//     - Any timeout, missing ACK, or byte != 0xFA in SEND/ACK/WAIT_FA: back to INHIBIT (retry
//       forever).
//     - No ps2_mouse update before RUN.
//   Not defined: FSM absent; block starts in RUN after reset; ps2_clk_o=ps2_dat_o=1 constantly.
// STRUCTURE
//   Package ps2_pkg:
//     - Frame-length constant (11).
//     - Status bit indices (BTN_L=0, BTN_R=1, BTN_M=2, ALWAYS1=3, XS=4, YS=5, XO=6, YO=7).
//     - Command/response bytes CMD_ENABLE=8'hF4, RSP_ACK=8'hFA.
//     - Init FSM state enum.
//   Sub-module ps2_rx_frame:
//     - Contains synchronisers, glitch filter, 11-bit shift register, parity check and timeout.
//     - Outputs byte_valid/byte_err strobes plus fall_edge for the init FSM.
//   Top level holds packet assembly, publish logic and the optional init FSM.
// TESTING
//   1. Frames 0x09,0x05,0xFB (-5) -> one cycle after last stop: ps2_mouse=25'h1_FB_05_09.
//   2. Second identical packet -> bit24 returns to 0, [23:0] unchanged.
//   3. Byte 0x01 (bit3=0), then 0x08,0x10,0x20 -> 0x01 dropped; publish {20,10,08},
//      exactly one toggle.
//   4. Parity error in byte 1 -> no publish. Next valid 3-byte packet publishes normally.
//   5. Two bytes sent, then 3 ms idle, then a full packet -> only the full packet publishes,
//      bytes aligned from index 0.
//   6. 3-cycle glitch low on ps2_clk mid-frame (FILTER_CYCLES=8) -> ignored; byte decodes
//      correctly.
//   7. Reset asserted mid-frame -> ps2_mouse=0, pins released. A following packet decodes
//      from index 0.
//   8. PS2_MOUSE_INIT_EN, device model:
//      - clk_o held low >=120 us; device receives 0xF4 with parity 0; model ACKs and returns
//        0xFA.
//      - 0xFA not published.
//      - Subsequent packet publishes.
//      - Repeat with missing ACK -> new INHIBIT observed.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the native PS/2 mouse host.
// Frame geometry, status bit positions, command bytes, init FSM states.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum int {
        BTN_L   = 0,
        BTN_R   = 1,
        BTN_M   = 2,
        ALWAYS1 = 3,
        XS      = 4,
        YS      = 5,
        XO      = 6,
        YO      = 7
    } stat_bit_e;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_FA,
        ST_RUN
    } init_st_e;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [31:0] us_cycles(
        input longint hz,
        input longint us
    );
        return 32'(hz * us / 64'd1000000);
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Pin-level and mouse-bus bundle of the PS/2 mouse host.
// master = host side, slave = board/pin side.
interface ps2_mouse_rx_if;

    logic        ps2_clk_i;
    logic        ps2_dat_i;
    logic        ps2_clk_o;
    logic        ps2_dat_o;
    logic [24:0] ps2_mouse;

    modport master (
        input  ps2_clk_i,
        input  ps2_dat_i,
        output ps2_clk_o,
        output ps2_dat_o,
        output ps2_mouse
    );

    modport slave (
        output ps2_clk_i,
        output ps2_dat_i,
        input  ps2_clk_o,
        input  ps2_dat_o,
        input  ps2_mouse
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// Device->host frame receiver: synchronisers, clock glitch filter,
// 11-bit deserialiser with start/parity/stop check, and idle timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int          FILTER_CYCLES = 8,
    parameter logic [31:0] TO_CYCLES     = 32'd100000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       clk_in,
    input  logic       dat_in,
    input  logic       hold,
    output logic       fall_edge,
    output logic       tmo,
    output logic       dat,
    output logic       byte_valid,
    output logic       byte_err,
    output logic [7:0] byte_data
);

    localparam logic [7:0] FC_MAX = 8'(FILTER_CYCLES - 1);

    logic [1:0]  c_sync;
    logic [1:0]  d_sync;
    logic        fclk;
    logic [7:0]  fcnt;
    logic [3:0]  bitcnt;
    logic [9:0]  sh;
    logic [10:0] full;
    logic [31:0] tcnt;
    logic        last;
    logic        ok;

    assign dat       = d_sync[1];
    assign fall_edge = fclk && !c_sync[1] && (fcnt == FC_MAX);
    assign full      = {d_sync[1], sh};
    assign last      = fall_edge &&
                       (bitcnt == 4'(FRAME_BITS - 1));
    assign ok        = !full[0] && full[10] && (^full[9:1]);
    assign byte_data = full[8:1];
    assign byte_valid = last && ok;
    assign byte_err   = last && !ok;
    // Expiry is a one-shot; an edge in the same cycle wins.
    assign tmo = (tcnt == 32'd1) && !fall_edge;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            fclk   <= 1'b1;
            fcnt   <= 8'd0;
            bitcnt <= 4'd0;
            sh     <= 10'd0;
            tcnt   <= 32'd0;
        end else begin
            c_sync <= {c_sync[0], clk_in};
            d_sync <= {d_sync[0], dat_in};
            if (c_sync[1] == fclk) begin
                fcnt <= 8'd0;
            end else if (fcnt == FC_MAX) begin
                fclk <= c_sync[1];
                fcnt <= 8'd0;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
            if (fall_edge) begin
                tcnt <= TO_CYCLES;
            end else if (tcnt != 32'd0) begin
                tcnt <= tcnt - 32'd1;
            end
            if (hold || tmo) begin
                bitcnt <= 4'd0;
            end else if (fall_edge) begin
                sh     <= full[10:1];
                bitcnt <= last ? 4'd0 : bitcnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// Native PS/2 mouse host: 3-byte packet assembly onto the 25-bit mouse bus.
// Define PS2_MOUSE_INIT_EN to send Enable Data Reporting after reset.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int FILTER_CYCLES = 8,
    parameter int TIMEOUT_US    = 2000
) (
    input  logic          clk_sys,
    input  logic          reset,
    ps2_mouse_rx_if.master bus
);

    localparam logic [31:0] TO_CYC =
        us_cycles(longint'(CLK_HZ), longint'(TIMEOUT_US));

    logic        fall_edge;
    logic        tmo;
    logic        dat;
    logic        byte_valid;
    logic        byte_err;
    logic [7:0]  byte_data;
    logic        hold;
    logic        run;
    logic [1:0]  idx;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [24:0] mouse;

    ps2_rx_frame #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .TO_CYCLES     (TO_CYC)
    ) u_frame (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .clk_in     (bus.ps2_clk_i),
        .dat_in     (bus.ps2_dat_i),
        .hold       (hold),
        .fall_edge  (fall_edge),
        .tmo        (tmo),
        .dat        (dat),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idx   <= 2'd0;
            b0    <= 8'd0;
            b1    <= 8'd0;
            mouse <= 25'd0;
        end else if (!run || tmo || byte_err) begin
            idx <= 2'd0;
        end else if (byte_valid) begin
            case (idx)
                2'd0: begin
                    if (byte_data[ALWAYS1]) begin
                        b0  <= byte_data;
                        idx <= 2'd1;
                    end
                end
                2'd1: begin
                    b1  <= byte_data;
                    idx <= 2'd2;
                end
                default: begin
                    mouse <= {~mouse[24], byte_data, b1, b0};
                    idx   <= 2'd0;
                end
            endcase
        end
    end

    assign bus.ps2_mouse = mouse;

`ifdef PS2_MOUSE_INIT_EN
    localparam logic [31:0] WAIT_CYC =
        us_cycles(longint'(CLK_HZ), 64'd500000);
    localparam logic [31:0] INH_CYC =
        us_cycles(longint'(CLK_HZ), 64'd120);
    localparam logic [10:0] TX_FRAME =
        {1'b1, odd_par(CMD_ENABLE), CMD_ENABLE, 1'b0};

    init_st_e    st;
    init_st_e    st_n;
    logic [31:0] tmr;
    logic [31:0] tmr_val;
    logic        tmr_ld;
    logic [3:0]  tx_cnt;
    logic [3:0]  tx_cnt_n;
    logic        clk_o;
    logic        dat_o;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            st     <= ST_WAIT;
            tmr    <= WAIT_CYC;
            tx_cnt <= 4'd0;
        end else begin
            st     <= st_n;
            tx_cnt <= tx_cnt_n;
            if (tmr_ld) begin
                tmr <= tmr_val;
            end else if (tmr != 32'd0) begin
                tmr <= tmr - 32'd1;
            end
        end
    end

    always_comb begin
        st_n     = st;
        tmr_ld   = 1'b0;
        tmr_val  = TO_CYC;
        tx_cnt_n = tx_cnt;
        clk_o    = 1'b1;
        dat_o    = 1'b1;
        hold     = 1'b1;
        unique case (st)
            ST_WAIT: begin
                if (tmr == 32'd0) st_n = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                clk_o = 1'b0;
                if (tmr == 32'd0) st_n = ST_REQ;
            end
            ST_REQ: begin
                clk_o    = 1'b0;
                dat_o    = 1'b0;
                tx_cnt_n = 4'd0;
                tmr_ld   = 1'b1;
                st_n     = ST_SEND;
            end
            ST_SEND: begin
                // Start bit stays on the line until the first device edge.
                dat_o = TX_FRAME[tx_cnt];
                if (fall_edge) begin
                    tmr_ld   = 1'b1;
                    tx_cnt_n = tx_cnt + 4'd1;
                    if (tx_cnt == 4'd9) st_n = ST_ACK;
                end else if (tmr == 32'd0) begin
                    st_n = ST_INHIBIT;
                end
            end
            ST_ACK: begin
                if (fall_edge) begin
                    tmr_ld = 1'b1;
                    st_n   = dat ? ST_INHIBIT : ST_WAIT_FA;
                end else if (tmr == 32'd0) begin
                    st_n = ST_INHIBIT;
                end
            end
            ST_WAIT_FA: begin
                hold = 1'b0;
                if (byte_valid) begin
                    st_n = (byte_data == RSP_ACK) ? ST_RUN
                                                  : ST_INHIBIT;
                end else if (byte_err || tmr == 32'd0) begin
                    st_n = ST_INHIBIT;
                end else if (fall_edge) begin
                    tmr_ld = 1'b1;
                end
            end
            ST_RUN: begin
                hold = 1'b0;
            end
            default: begin
                st_n = ST_INHIBIT;
            end
        endcase
        if (st_n == ST_INHIBIT && st != ST_INHIBIT) begin
            tmr_ld  = 1'b1;
            tmr_val = INH_CYC;
        end
    end

    assign run           = (st == ST_RUN);
    assign bus.ps2_clk_o = clk_o;
    assign bus.ps2_dat_o = dat_o;
`else
    logic unused_init;

    assign unused_init   = fall_edge ^ dat;
    assign hold          = 1'b0;
    assign run           = 1'b1;
    assign bus.ps2_clk_o = 1'b1;
    assign bus.ps2_dat_o = 1'b1;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: PS/2 device model, packet reference model.
// Covers the PS2_MOUSE_INIT_EN handshake when that macro is defined.
module tb_ps2_mouse_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;
    localparam int IDLE = 300;

    logic        clk_sys;
    logic        reset;
    logic        dev_clk;
    logic        dev_dat;
    int          n_pass;
    int          n_total;
    logic [7:0]  q[$];
    logic [24:0] exp_mouse;

    ps2_mouse_rx_if bus ();

    assign bus.ps2_clk_i = dev_clk & bus.ps2_clk_o;
    assign bus.ps2_dat_i = dev_dat & bus.ps2_dat_o;

    ps2_mouse_rx #(
        .CLK_HZ        (100_000),
        .FILTER_CYCLES (8),
        .TIMEOUT_US    (2000)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Packet model: a queue of accepted bytes, published at three.
    function automatic void model_byte(
        input logic [7:0] b,
        input bit         good
    );
        if (!good) begin
            q.delete();
        end else if (q.size() != 0 || b[3]) begin
            q.push_back(b);
            if (q.size() == 3) begin
                exp_mouse = {~exp_mouse[24], q[2], q[1], q[0]};
                q.delete();
            end
        end
    endfunction

    task automatic send_frame(
        input logic [7:0] b,
        input bit         bad_par,
        input int         nbits,
        input int         glitch_at
    );
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat = f[i];
            tick(5);
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
            if (i == glitch_at) begin
                tick(11);
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                tick(HALF - 19);
            end else begin
                tick(HALF - 5);
            end
        end
        dev_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_frame(b, bad, FRAME_BITS, -1);
        model_byte(b, !bad);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_total++;
        if (bus.ps2_mouse !== 25'd0)
            $display("FAIL reset_mouse: got %h want 0", bus.ps2_mouse);
        else n_pass++;
        n_total++;
        if (bus.ps2_clk_o !== 1'b1)
            $display("FAIL reset_clk_o: got %b want 1", bus.ps2_clk_o);
        else n_pass++;
        n_total++;
        if (bus.ps2_dat_o !== 1'b1)
            $display("FAIL reset_dat_o: got %b want 1", bus.ps2_dat_o);
        else n_pass++;
        reset = 1'b0;
        q.delete();
        exp_mouse = 25'd0;
        tick(2);
    endtask

    task automatic test_basic;
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'd0)
            $display("FAIL basic_early: got %h want 0", bus.ps2_mouse);
        else n_pass++;
        send_byte(8'hFB, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h1FB0509)
            $display("FAIL basic_pkt: got %h want 1fb0509",
                     bus.ps2_mouse);
        else n_pass++;
    endtask

    task automatic test_repeat;
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hFB, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h0FB0509)
            $display("FAIL repeat_pkt: got %h want 0fb0509",
                     bus.ps2_mouse);
        else n_pass++;
    endtask

    task automatic test_align;
        send_byte(8'h01, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h10, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h0FB0509)
            $display("FAIL align_early: got %h want 0fb0509",
                     bus.ps2_mouse);
        else n_pass++;
        send_byte(8'h20, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h1201008)
            $display("FAIL align_pkt: got %h want 1201008",
                     bus.ps2_mouse);
        else n_pass++;
    endtask

    task automatic test_parity;
        send_byte(8'h18, 1'b0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h1201008)
            $display("FAIL parity_nopub: got %h want 1201008",
                     bus.ps2_mouse);
        else n_pass++;
        send_byte(8'($urandom) | 8'h08, 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        n_total++;
        if (bus.ps2_mouse !== exp_mouse)
            $display("FAIL parity_next: got %h want %h",
                     bus.ps2_mouse, exp_mouse);
        else n_pass++;
    endtask

    task automatic test_timeout;
        send_byte(8'($urandom) | 8'h08, 1'b0);
        send_byte(8'($urandom), 1'b0);
        tick(IDLE);
        q.delete();
        send_byte(8'($urandom) | 8'h08, 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        n_total++;
        if (bus.ps2_mouse !== exp_mouse)
            $display("FAIL timeout_pkt: got %h want %h",
                     bus.ps2_mouse, exp_mouse);
        else n_pass++;
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        b = 8'($urandom) | 8'h08;
        send_frame(b, 1'b0, FRAME_BITS, 4);
        model_byte(b, 1'b1);
        b = 8'($urandom);
        send_frame(b, 1'b0, FRAME_BITS, 7);
        model_byte(b, 1'b1);
        send_byte(8'($urandom), 1'b0);
        n_total++;
        if (bus.ps2_mouse !== exp_mouse)
            $display("FAIL glitch_pkt: got %h want %h",
                     bus.ps2_mouse, exp_mouse);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        send_byte(8'h0C, 1'b0);
        send_frame(8'h5A, 1'b0, 5, -1);
        reset = 1'b1;
        tick(2);
        n_total++;
        if (bus.ps2_mouse !== 25'd0)
            $display("FAIL midrst_mouse: got %h want 0", bus.ps2_mouse);
        else n_pass++;
        n_total++;
        if ({bus.ps2_clk_o, bus.ps2_dat_o} !== 2'b11)
            $display("FAIL midrst_pins: got %b want 11",
                     {bus.ps2_clk_o, bus.ps2_dat_o});
        else n_pass++;
        reset = 1'b0;
        q.delete();
        exp_mouse = 25'd0;
        tick(2);
        send_byte(8'($urandom) | 8'h08, 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        n_total++;
        if (bus.ps2_mouse !== exp_mouse || exp_mouse[24] !== 1'b1)
            $display("FAIL midrst_pkt: got %h want %h",
                     bus.ps2_mouse, exp_mouse);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom), $urandom_range(0, 7) == 0);
            n_total++;
            if (bus.ps2_mouse !== exp_mouse)
                $display("FAIL rand_%0d: got %h want %h",
                         i, bus.ps2_mouse, exp_mouse);
            else n_pass++;
        end
        tick(IDLE);
        q.delete();
    endtask

    task automatic test_back_to_back;
        for (int p = 0; p < 2; p++) begin
            send_byte(8'($urandom) | 8'h08, 1'b0);
            send_byte(8'($urandom), 1'b0);
            send_byte(8'($urandom), 1'b0);
            n_total++;
            if (bus.ps2_mouse !== exp_mouse)
                $display("FAIL b2b_%0d: got %h want %h",
                         p, bus.ps2_mouse, exp_mouse);
            else n_pass++;
        end
    endtask

`ifdef PS2_MOUSE_INIT_EN
    task automatic handshake(input bit ack);
        int         n;
        logic [7:0] rx;
        logic       par;
        logic       stp;
        n = 0;
        while (bus.ps2_clk_o !== 1'b0 && n < 60000) begin
            tick(1);
            n++;
        end
        n_total++;
        if (bus.ps2_clk_o !== 1'b0)
            $display("FAIL inhibit_seen: got %b want 0", bus.ps2_clk_o);
        else n_pass++;
        n = 0;
        while (bus.ps2_clk_o === 1'b0 && n < 1000) begin
            tick(1);
            n++;
        end
        n_total++;
        if (n < 12 || n >= 1000)
            $display("FAIL inhibit_len: got %0d want 12..999", n);
        else n_pass++;
        n_total++;
        if (bus.ps2_dat_o !== 1'b0)
            $display("FAIL req_start: got %b want 0", bus.ps2_dat_o);
        else n_pass++;
        rx  = 8'd0;
        par = 1'b1;
        for (int k = 0; k < 9; k++) begin
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
            if (k < 8) rx[k] = bus.ps2_dat_o;
            else par = bus.ps2_dat_o;
            tick(HALF);
        end
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        stp = bus.ps2_dat_o;
        tick(HALF);
        n_total++;
        if (rx !== CMD_ENABLE || par !== 1'b0 || stp !== 1'b1)
            $display("FAIL tx_byte: got %h/%b/%b want f4/0/1",
                     rx, par, stp);
        else n_pass++;
        if (ack) dev_dat = 1'b0;
        tick(5);
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        tick(HALF - 5);
        dev_dat = 1'b1;
    endtask

    task automatic test_init;
        int n;
        handshake(1'b0);
        n = 0;
        while (bus.ps2_clk_o !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        n_total++;
        if (bus.ps2_clk_o !== 1'b0)
            $display("FAIL noack_retry: got %b want 0", bus.ps2_clk_o);
        else n_pass++;
        handshake(1'b1);
        tick(HALF);
        send_frame(RSP_ACK, 1'b0, FRAME_BITS, -1);
        n_total++;
        if (bus.ps2_mouse !== 25'd0)
            $display("FAIL fa_hidden: got %h want 0", bus.ps2_mouse);
        else n_pass++;
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        n_total++;
        if (bus.ps2_mouse !== 25'h1020108)
            $display("FAIL init_pkt: got %h want 1020108",
                     bus.ps2_mouse);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        dev_clk   = 1'b1;
        dev_dat   = 1'b1;
        exp_mouse = 25'd0;
        tick(2);
        test_reset;
`ifdef PS2_MOUSE_INIT_EN
        test_init;
`else
        test_basic;
        test_repeat;
        test_align;
        test_parity;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_random;
        test_back_to_back;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
